// File: rtl/gp_frame_reader_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// gp_frame_reader_if : GP pixel write port and pixel stream port of the frame reader
// Revision: 1.0
// ============================================================================
interface gp_frame_reader_if #(
    parameter int AW = 18
);
    logic          gp_we;
    logic [31:0]   gp_data;
    logic          frame_flush;
    logic [7:0]    pix_data;
    logic          pix_valid;
    logic          pix_ready;
    logic          pix_last;
    logic [AW-1:0] pix_addr;
    logic          busy;
    logic          overflow;

    modport master (
        output gp_we, gp_data, frame_flush, pix_ready,
        input  pix_data, pix_valid, pix_last, pix_addr, busy, overflow
    );

    modport slave (
        input  gp_we, gp_data, frame_flush, pix_ready,
        output pix_data, pix_valid, pix_last, pix_addr, busy, overflow
    );
endinterface
`default_nettype wire

// File: rtl/gp_frame_reader.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// gp_frame_reader : output frame buffer filled by GP writes, drained in address order
// Revision: 1.0
// ============================================================================
module gp_frame_reader #(
    parameter int NPIX = 153600,
    parameter int AW   = 18
) (
    input  logic                 clk,
    input  logic                 rst,
    gp_frame_reader_if.slave     bus
);
    localparam logic [AW-1:0] c_last_addr = AW'(NPIX - 1);

    typedef enum logic [0:0] {
        FILL  = 1'b0,
        DRAIN = 1'b1
    } state_t;

    state_t        r_state;
    state_t        w_state_nxt;

    logic [7:0]    r_mem [NPIX];

    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    // Holds frame_len-1 so a full frame of 2^AW pixels still fits in AW bits
    logic [AW-1:0] r_last_idx;
    logic          r_rd_done;
    logic          r_overflow;

    logic          r_out_vld;
    logic          r_out_last;
    logic [7:0]    r_out_data;
    logic [AW-1:0] r_out_addr;
    logic          r_skd_vld;
    logic          r_skd_last;
    logic [7:0]    r_skd_data;
    logic [AW-1:0] r_skd_addr;

    logic          w_wr_en;
    logic          w_start;
    logic [AW-1:0] w_start_last;
    logic          w_accept;
    logic          w_issue;
    logic [7:0]    w_rd_data;
    logic          w_rd_last;
    logic          w_unused_bits;

    assign w_unused_bits = ^bus.gp_data[31:8];

    assign w_accept  = r_out_vld && bus.pix_ready;
    // Prefetch only while the two-entry buffer has room after this cycle's handshake
    assign w_issue   = (r_state == DRAIN) && !r_rd_done && (!r_skd_vld || w_accept);
    assign w_rd_data = r_mem[r_rd_ptr];
    assign w_rd_last = (r_rd_ptr == r_last_idx);

    always_comb begin
        w_state_nxt  = r_state;
        w_wr_en      = 1'b0;
        w_start      = 1'b0;
        w_start_last = r_wr_ptr;
        case (r_state)
            FILL: begin
                w_wr_en = bus.gp_we;
                if (bus.gp_we && (r_wr_ptr == c_last_addr)) begin
                    w_start      = 1'b1;
                    w_start_last = c_last_addr;
                end else if (bus.frame_flush && ((r_wr_ptr != '0) || bus.gp_we)) begin
                    w_start      = 1'b1;
                    w_start_last = bus.gp_we ? r_wr_ptr : (r_wr_ptr - AW'(1));
                end
                if (w_start) begin
                    w_state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                if (w_accept && r_out_last) begin
                    w_state_nxt = FILL;
                end
            end
            default: w_state_nxt = FILL;
        endcase
    end

    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            r_mem[r_wr_ptr] <= bus.gp_data[7:0];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= FILL;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_last_idx <= '0;
            r_rd_done  <= 1'b0;
            r_overflow <= 1'b0;
            r_out_vld  <= 1'b0;
            r_out_last <= 1'b0;
            r_out_data <= '0;
            r_out_addr <= '0;
            r_skd_vld  <= 1'b0;
            r_skd_last <= 1'b0;
            r_skd_data <= '0;
            r_skd_addr <= '0;
        end else begin
            r_state <= w_state_nxt;

            if (w_wr_en) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_start) begin
                r_last_idx <= w_start_last;
            end
            if ((r_state == DRAIN) && bus.gp_we) begin
                r_overflow <= 1'b1;
            end

            if (w_issue) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
                if (w_rd_last) begin
                    r_rd_done <= 1'b1;
                end
            end

            if (w_accept) begin
                if (r_skd_vld) begin
                    r_out_data <= r_skd_data;
                    r_out_addr <= r_skd_addr;
                    r_out_last <= r_skd_last;
                    r_skd_vld  <= w_issue;
                    if (w_issue) begin
                        r_skd_data <= w_rd_data;
                        r_skd_addr <= r_rd_ptr;
                        r_skd_last <= w_rd_last;
                    end
                end else begin
                    r_out_vld <= w_issue;
                    if (w_issue) begin
                        r_out_data <= w_rd_data;
                        r_out_addr <= r_rd_ptr;
                        r_out_last <= w_rd_last;
                    end
                end
            end else if (!r_out_vld) begin
                r_out_vld <= w_issue;
                if (w_issue) begin
                    r_out_data <= w_rd_data;
                    r_out_addr <= r_rd_ptr;
                    r_out_last <= w_rd_last;
                end
            end else if (w_issue) begin
                r_skd_vld  <= 1'b1;
                r_skd_data <= w_rd_data;
                r_skd_addr <= r_rd_ptr;
                r_skd_last <= w_rd_last;
            end

            // Final handshake rearms the buffer for the next frame
            if (w_accept && r_out_last) begin
                r_wr_ptr  <= '0;
                r_rd_ptr  <= '0;
                r_rd_done <= 1'b0;
            end
        end
    end

    assign bus.pix_data  = r_out_data;
    assign bus.pix_valid = r_out_vld;
    assign bus.pix_last  = r_out_vld && r_out_last;
    assign bus.pix_addr  = r_out_addr;
    assign bus.busy      = (r_state == DRAIN);
    assign bus.overflow  = r_overflow;
endmodule
`default_nettype wire

// File: tb/tb_gp_frame_reader.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// tb_gp_frame_reader : frame-vector table plus hand sequences, scoreboarded pixel stream
// Revision: 1.0
// ============================================================================
module tb_gp_frame_reader;
    localparam int NPIX = 8;
    localparam int AW   = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    gp_frame_reader_if #(.AW(AW)) bus ();

    gp_frame_reader #(.NPIX(NPIX), .AW(AW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct packed {
        logic [7:0]    data;
        logic [AW-1:0] addr;
        logic          last;
    } beat_t;

    typedef struct {
        int         nw;
        bit         flush_with_last;
        int         rmode;
        logic [7:0] base;
        int         exp_len;
        int         exp_cycles;
    } vec_t;

    beat_t sb[$];
    vec_t  vecs[5];
    int    n_chk    = 0;
    int    n_fail   = 0;
    int    beat_cnt = 0;
    int    rmode    = 2;
    bit    stall_prev = 1'b0;
    beat_t held;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %0h required %0h", name, act, exp);
        end
    endtask

    // Sink readiness: 0 = always ready, 1 = random, 2 = held low
    initial begin
        bus.pix_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (rmode)
                0:       bus.pix_ready = 1'b1;
                1:       bus.pix_ready = 1'($urandom_range(0, 1));
                default: bus.pix_ready = 1'b0;
            endcase
        end
    end

    // Stream monitor: pops the scoreboard on each beat that the next edge accepts
    always @(negedge clk) begin
        beat_t got;
        beat_t exp;
        got = {bus.pix_data, bus.pix_addr, bus.pix_last};
        if (rst) begin
            stall_prev = 1'b0;
        end else begin
            if (stall_prev) begin
                chk("stall_valid", {31'd0, bus.pix_valid}, 32'd1);
                chk("stall_stable", 32'(got), 32'(held));
            end
            if (bus.pix_valid && bus.pix_ready) begin
                if (sb.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL unexpected_beat: actual %0h required none", got);
                end else begin
                    exp = sb.pop_front();
                    chk("beat", 32'(got), 32'(exp));
                end
                beat_cnt++;
                stall_prev = 1'b0;
            end else if (bus.pix_valid) begin
                stall_prev = 1'b1;
                held = got;
            end else begin
                stall_prev = 1'b0;
            end
        end
    end

    task automatic write_frame(input int nw, input bit fl_last, input logic [7:0] base, input int len);
        beat_t b;
        for (int i = 0; i < nw; i++) begin
            b.data = 8'(base + 8'(i));
            b.addr = AW'(i);
            b.last = (i == len - 1);
            sb.push_back(b);
            bus.gp_we       = 1'b1;
            bus.gp_data     = {24'hDEADBE, b.data};
            bus.frame_flush = fl_last && (i == nw - 1);
            @(posedge clk);
            #1;
        end
        bus.gp_we       = 1'b0;
        bus.frame_flush = 1'b0;
        if (!fl_last && nw < NPIX) begin
            bus.frame_flush = 1'b1;
            @(posedge clk);
            #1;
            bus.frame_flush = 1'b0;
        end
        chk("busy_rise", {31'd0, bus.busy}, 32'd1);
        chk("valid_low_at_entry", {31'd0, bus.pix_valid}, 32'd0);
    endtask

    task automatic wait_drain(input int exp_cycles);
        int cyc;
        cyc = 0;
        while (bus.busy && cyc < 200) begin
            @(posedge clk);
            #1;
            cyc++;
            if (cyc == 1 && exp_cycles > 0) begin
                chk("first_valid", {31'd0, bus.pix_valid}, 32'd1);
                chk("first_addr", 32'(bus.pix_addr), 32'd0);
            end
        end
        chk("drain_done", {31'd0, bus.busy}, 32'd0);
        chk("valid_after_drain", {31'd0, bus.pix_valid}, 32'd0);
        if (exp_cycles > 0) begin
            chk("drain_cycles", 32'(cyc), 32'(exp_cycles));
        end
        chk("sb_empty", 32'(sb.size()), 32'd0);
    endtask

    initial begin
        int start;
        int c;

        vecs[0] = '{8, 1'b0, 0, 8'h11, 8, 9};
        vecs[1] = '{1, 1'b0, 0, 8'hA5, 1, 2};
        vecs[2] = '{3, 1'b1, 0, 8'h01, 3, 4};
        vecs[3] = '{8, 1'b0, 1, 8'h40, 8, -1};
        vecs[4] = '{5, 1'b0, 1, 8'hC0, 5, -1};

        bus.gp_we       = 1'b0;
        bus.gp_data     = '0;
        bus.frame_flush = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid", {31'd0, bus.pix_valid}, 32'd0);
        chk("rst_last", {31'd0, bus.pix_last}, 32'd0);
        chk("rst_data", 32'(bus.pix_data), 32'd0);
        chk("rst_addr", 32'(bus.pix_addr), 32'd0);
        chk("rst_busy", {31'd0, bus.busy}, 32'd0);
        chk("rst_overflow", {31'd0, bus.overflow}, 32'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        for (int v = 0; v < 5; v++) begin
            rmode = vecs[v].rmode;
            @(posedge clk);
            #1;
            write_frame(vecs[v].nw, vecs[v].flush_with_last, vecs[v].base, vecs[v].exp_len);
            wait_drain(vecs[v].exp_cycles);
        end

        // Flush on an empty buffer
        bus.frame_flush = 1'b1;
        @(posedge clk);
        #1;
        bus.frame_flush = 1'b0;
        chk("empty_flush_busy0", {31'd0, bus.busy}, 32'd0);
        @(posedge clk);
        #1;
        chk("empty_flush_busy1", {31'd0, bus.busy}, 32'd0);

        // Write while draining is dropped and sets sticky overflow
        rmode = 2;
        write_frame(4, 1'b0, 8'h20, 4);
        bus.gp_we   = 1'b1;
        bus.gp_data = 32'h0000_0077;
        @(posedge clk);
        #1;
        bus.gp_we = 1'b0;
        chk("overflow_set", {31'd0, bus.overflow}, 32'd1);
        rmode = 0;
        wait_drain(-1);
        chk("overflow_sticky", {31'd0, bus.overflow}, 32'd1);
        write_frame(5, 1'b0, 8'h30, 5);
        wait_drain(6);
        chk("overflow_still", {31'd0, bus.overflow}, 32'd1);

        // Reset in the middle of a drain
        write_frame(8, 1'b0, 8'h50, 8);
        start = beat_cnt;
        c = 0;
        while ((beat_cnt - start) < 3 && c < 100) begin
            @(negedge clk);
            c++;
        end
        chk("three_beats", 32'(beat_cnt - start), 32'd3);
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        chk("async_rst_valid", {31'd0, bus.pix_valid}, 32'd0);
        chk("async_rst_busy", {31'd0, bus.busy}, 32'd0);
        sb.delete();
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("rst_clears_overflow", {31'd0, bus.overflow}, 32'd0);
        @(posedge clk);
        #1;
        write_frame(2, 1'b0, 8'h90, 2);
        wait_drain(3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
